lc3_datapath_memif: RTL

//  Parametrised successor of the LC-3 datapath. It adds a registered memory handshake engine
//  (MAR/MDR <-> external memory) with timeout, plus sticky error reporting.
//  It also adds explicit bus-conflict detection and a configurable PC reset vector.
//  It sits between the ISDU control FSM and the memory subsystem; the FSM pulses MEM_START
//  and waits for MEM_DONE instead of counting fixed wait states.

---
 rtl/lc3_datapath_memif_if.sv | 22 ++
 rtl/lc3_datapath_memif.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/lc3_datapath_memif_if.sv
// Memory-side bus of the LC-3 datapath.
// The datapath drives requests (master), the memory subsystem answers (slave).
interface lc3_datapath_memif_if #(
    parameter int WIDTH = 16
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lc3_datapath_memif.sv
// LC-3 datapath with a registered MAR/MDR memory handshake engine,
// sticky timeout error, bus-conflict detection and a reset vector.
module lc3_datapath_memif #(
    parameter int               WIDTH       = 16,
    parameter int               MEM_TIMEOUT = 15,
    parameter logic [WIDTH-1:0] RESET_PC    = 'h3000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [3:0]       GATE,
    input  logic [6:0]       LD,
    input  logic [3:0]       MUXSEL,
    input  logic [1:0]       PCMUX,
    input  logic [1:0]       ADDR2MUX,
    input  logic [1:0]       ALUK,
    input  logic             MEM_START,
    input  logic             MEM_WE,
    output logic             MEM_BUSY,
    output logic             MEM_DONE,
    output logic             MEM_ERR,
    lc3_datapath_memif_if.master mem,
    output logic             BUS_CONFLICT,
    output logic             BEN_OUT,
    output logic [2:0]       NZP,
    output logic [WIDTH-1:0] MAR,
    output logic [WIDTH-1:0] MDR,
    output logic [WIDTH-1:0] IR,
    output logic [WIDTH-1:0] PC
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} mstate_t;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    mstate_t          state, state_nx;
    logic [7:0]       timer, timer_inc;
    logic             timeout, rd_done;
    logic [WIDTH-1:0] regs [8];
    logic [2:0]       dr, sr1;
    logic [WIDTH-1:0] sr1_val, alu_b, alu_out;
    logic [WIDTH-1:0] addr1, addr2, adder, bus, pc_inc;
    logic [WIDTH-1:0] sext5, sext6, sext9, sext11;
    logic             bus_n, bus_z;
    logic             unused_ir;

    assign sext5     = {{(WIDTH-5){IR[4]}}, IR[4:0]};
    assign sext6     = {{(WIDTH-6){IR[5]}}, IR[5:0]};
    assign sext9     = {{(WIDTH-9){IR[8]}}, IR[8:0]};
    assign sext11    = {{(WIDTH-11){IR[10]}}, IR[10:0]};
    assign unused_ir = ^IR[WIDTH-1:12];

    // Register selects, ALU, address adder and the gated bus
    always_comb begin
        dr      = MUXSEL[3] ? 3'd7 : IR[11:9];
        sr1     = MUXSEL[2] ? IR[8:6] : IR[11:9];
        sr1_val = regs[sr1];
        alu_b   = MUXSEL[1] ? sext5 : regs[IR[2:0]];
        unique case (ALUK)
            2'd0: alu_out = sr1_val + alu_b;
            2'd1: alu_out = sr1_val & alu_b;
            2'd2: alu_out = ~sr1_val;
            2'd3: alu_out = sr1_val;
        endcase
        unique case (ADDR2MUX)
            2'd0: addr2 = '0;
            2'd1: addr2 = sext6;
            2'd2: addr2 = sext9;
            2'd3: addr2 = sext11;
        endcase
        addr1  = MUXSEL[0] ? sr1_val : PC;
        adder  = addr1 + addr2;
        pc_inc = PC + 1'b1;
        BUS_CONFLICT = (GATE & (GATE - 4'd1)) != 4'd0;
        case (GATE)
            4'b1000: bus = MDR;
            4'b0100: bus = PC;
            4'b0010: bus = adder;
            4'b0001: bus = alu_out;
            default: bus = '0;
        endcase
        bus_n = bus[WIDTH-1];
        bus_z = bus == '0;
    end

    // Memory engine next state and status outputs
    always_comb begin
        state_nx     = state;
        MEM_BUSY     = state != IDLE;
        MEM_DONE     = state == DONE;
        mem.mem_req  = state == REQ;
        timer_inc    = timer + 8'd1;
        timeout      = (state == REQ) && !mem.mem_ack && (timer_inc == TMO);
        rd_done      = (state == REQ) && mem.mem_ack && !mem.mem_we;
        case (state)
            IDLE:    if (MEM_START) state_nx = REQ;
            REQ:     if (mem.mem_ack || timeout) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Memory engine state register
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Access latches, timeout timer and sticky error
    always_ff @(posedge Clk) begin
        if (Reset) begin
            timer         <= '0;
            MEM_ERR       <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            if (state == IDLE && MEM_START) begin
                mem.mem_addr  <= MAR;
                mem.mem_wdata <= MDR;
                mem.mem_we    <= MEM_WE;
                timer         <= '0;
            end
            if (state == REQ) timer <= timer_inc;
            if (timeout) MEM_ERR <= 1'b1;
        end
    end

    // Architectural registers, register file and condition codes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC      <= RESET_PC;
            MAR     <= '0;
            MDR     <= '0;
            IR      <= '0;
            NZP     <= 3'b010;
            BEN_OUT <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            if (LD[6]) MAR <= bus;
            if (rd_done)    MDR <= mem.mem_rdata;
            else if (LD[5]) MDR <= bus;
            if (LD[4]) IR <= bus;
            if (LD[3]) begin
                unique case (PCMUX)
                    2'd0: PC <= pc_inc;
                    2'd1: PC <= bus;
                    2'd2: PC <= adder;
                    2'd3: PC <= PC;
                endcase
            end
            if (LD[2] && !BUS_CONFLICT)
                NZP <= {bus_n, bus_z, !bus_n && !bus_z};
            if (LD[1]) BEN_OUT <= |(IR[11:9] & NZP);
            if (LD[0]) regs[dr] <= bus;
        end
    end
endmodule
